cache_set_array: RTL and testbench

- Parametrised N-way set-associative data/tag array with valid and dirty bits and true-LRU replacement.
- Serves byte/half/word/dword reads and writes against a block, and reports hit or miss.
- Accepts line fills from the next level and emits dirty victims for write-back.
- Sits between the core-side cache controller and the L2/memory interface; successor to the fixed 8-way, hard-coded-tag set block.

---
 rtl/cache_set_array_if.sv | 45 ++++
 rtl/cache_set_array.sv | 253 +++++++++++++++++++++++++
 tb/tb_cache_set_array.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_set_array_if.sv
// Core/L2-facing bundle of the set array: request, response, fill and eviction signals.
// Latency: none, this file carries wiring only.
// Backpressure: req_ready/fill_ready are driven by the array; nothing is buffered here.
interface cache_set_array_if #(
    parameter int SET_W  = 6,
    parameter int TAG_W  = 24,
    parameter int OFF_W  = 6,
    parameter int LINE_W = 512
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_offset;
    logic [1:0]        req_size;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_err;
    logic [63:0]       resp_rdata;
    logic              fill_valid;
    logic              fill_ready;
    logic [SET_W-1:0]  fill_set;
    logic [TAG_W-1:0]  fill_tag;
    logic [LINE_W-1:0] fill_data;
    logic              evict_valid;
    logic [SET_W-1:0]  evict_set;
    logic [TAG_W-1:0]  evict_tag;
    logic [LINE_W-1:0] evict_data;

    modport master (
        output req_valid, req_write, req_set, req_tag, req_offset, req_size, req_wdata,
        input  req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
        output fill_valid, fill_set, fill_tag, fill_data,
        input  fill_ready, evict_valid, evict_set, evict_tag, evict_data
    );

    modport slave (
        input  req_valid, req_write, req_set, req_tag, req_offset, req_size, req_wdata,
        output req_ready, resp_valid, resp_hit, resp_err, resp_rdata,
        input  fill_valid, fill_set, fill_tag, fill_data,
        output fill_ready, evict_valid, evict_set, evict_tag, evict_data
    );
endinterface

// File: rtl/cache_set_array.sv
// N-way set-associative tag/data array with valid/dirty bits, true-LRU ages and dirty-victim eviction.
// Latency: request accepted at edge N responds at edge N+1; fill accepted at edge N installs/evicts at edge N+1.
// Backpressure: ready only in IDLE; a fill wins over a simultaneous request. Optional CACHE_STATS_EN adds hit/miss counters.
module cache_set_array #(
    parameter int WAYS        = 8,
    parameter int SETS        = 64,
    parameter int BLOCK_BYTES = 64,
    parameter int TAG_W       = 24
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    cache_set_array_if.slave  bus
);
    localparam int SET_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int LINE_W = BLOCK_BYTES * 8;
    localparam int WAY_W  = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t                               state_q;
    logic [LINE_W-1:0]                    data_q [SETS][WAYS];
    logic [TAG_W-1:0]                     tag_q  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]            valid_q, dirty_q;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;

    logic              rq_write_q;
    logic [SET_W-1:0]  rq_set_q;
    logic [TAG_W-1:0]  rq_tag_q;
    logic [OFF_W-1:0]  rq_off_q;
    logic [1:0]        rq_size_q;
    logic [63:0]       rq_wdata_q;
    logic [SET_W-1:0]  fl_set_q;
    logic [TAG_W-1:0]  fl_tag_q;
    logic [LINE_W-1:0] fl_data_q;

    logic              resp_valid_q, resp_hit_q, resp_err_q;
    logic [63:0]       resp_rdata_q;
    logic              evict_valid_q;
    logic [SET_W-1:0]  evict_set_q;
    logic [TAG_W-1:0]  evict_tag_q;
    logic [LINE_W-1:0] evict_data_q;

    logic fill_acc, req_acc;
    assign fill_acc = (state_q == IDLE) && bus.fill_valid;
    assign req_acc  = (state_q == IDLE) && bus.req_valid && !bus.fill_valid;

    assign bus.fill_ready  = (state_q == IDLE);
    assign bus.req_ready   = (state_q == IDLE) && !bus.fill_valid;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_set   = evict_set_q;
    assign bus.evict_tag   = evict_tag_q;
    assign bus.evict_data  = evict_data_q;

    logic              lk_hit, lk_err, lk_ok;
    logic [WAY_W-1:0]  lk_way;
    logic [OFF_W:0]    lk_end;
    logic [63:0]       lk_mask, lk_rdata;
    logic [LINE_W-1:0] lk_line, lk_shift, lk_wmask, lk_wline;

    // Lookup path: tag compare, line-end check, byte extraction and write merge
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[rq_set_q][w] && (tag_q[rq_set_q][w] == rq_tag_q)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
        lk_end = {1'b0, rq_off_q} + ((OFF_W+1)'(1) << rq_size_q);
        lk_err = lk_end > (OFF_W+1)'(BLOCK_BYTES);
        lk_ok  = lk_hit && !lk_err;
        case (rq_size_q)
            2'd0:    lk_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lk_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lk_mask = 64'h0000_0000_FFFF_FFFF;
            default: lk_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lk_line  = data_q[rq_set_q][lk_way];
        lk_shift = lk_line >> {rq_off_q, 3'b000};
        lk_rdata = lk_shift[63:0] & lk_mask;
        lk_wmask = LINE_W'(lk_mask) << {rq_off_q, 3'b000};
        lk_wline = (lk_line & ~lk_wmask) | (LINE_W'(rq_wdata_q & lk_mask) << {rq_off_q, 3'b000});
    end

    logic             fl_match, fl_inv, fl_evict;
    logic [WAY_W-1:0] fl_mway, fl_iway, fl_lway, fl_way;

    // Fill victim: same-tag way, else lowest invalid way, else the oldest way
    always_comb begin
        fl_match = 1'b0;
        fl_inv   = 1'b0;
        fl_mway  = '0;
        fl_iway  = '0;
        fl_lway  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!fl_match && valid_q[fl_set_q][w] && (tag_q[fl_set_q][w] == fl_tag_q)) begin
                fl_match = 1'b1;
                fl_mway  = WAY_W'(w);
            end
            if (!fl_inv && !valid_q[fl_set_q][w]) begin
                fl_inv  = 1'b1;
                fl_iway = WAY_W'(w);
            end
            if (age_q[fl_set_q][w] == WAY_W'(WAYS-1)) begin
                fl_lway = WAY_W'(w);
            end
        end
        fl_way   = fl_match ? fl_mway : (fl_inv ? fl_iway : fl_lway);
        fl_evict = !fl_match && valid_q[fl_set_q][fl_way] && dirty_q[fl_set_q][fl_way];
    end

    logic                       touch_en;
    logic [SET_W-1:0]           touch_set;
    logic [WAY_W-1:0]           touch_way, touch_age;
    logic [WAYS-1:0][WAY_W-1:0] age_row_d;

    // LRU touch: younger ways age by one, the touched way becomes MRU
    always_comb begin
        touch_en  = (state_q == FILL) || ((state_q == LOOKUP) && lk_ok);
        touch_set = (state_q == FILL) ? fl_set_q : rq_set_q;
        touch_way = (state_q == FILL) ? fl_way : lk_way;
        touch_age = age_q[touch_set][touch_way];
        age_row_d = age_q[touch_set];
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
                age_row_d[w] = '0;
            end else if (age_q[touch_set][w] < touch_age) begin
                age_row_d[w] = age_q[touch_set][w] + WAY_W'(1);
            end
        end
    end

    // Control FSM plus valid/dirty/age state and registered response/eviction strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_set_q   <= '0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
        end else begin
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_set_q   <= '0;
            evict_tag_q   <= '0;
            evict_data_q  <= '0;
            if (touch_en) begin
                age_q[touch_set] <= age_row_d;
            end
            case (state_q)
                IDLE: begin
                    if (fill_acc) begin
                        state_q <= FILL;
                    end else if (req_acc) begin
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= lk_ok;
                    resp_err_q   <= lk_err;
                    resp_rdata_q <= (lk_ok && !rq_write_q) ? lk_rdata : 64'd0;
                    if (lk_ok && rq_write_q) begin
                        dirty_q[rq_set_q][lk_way] <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                FILL: begin
                    if (fl_evict) begin
                        evict_valid_q <= 1'b1;
                        evict_set_q   <= fl_set_q;
                        evict_tag_q   <= tag_q[fl_set_q][fl_way];
                        evict_data_q  <= data_q[fl_set_q][fl_way];
                    end
                    valid_q[fl_set_q][fl_way] <= 1'b1;
                    dirty_q[fl_set_q][fl_way] <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line/tag storage and request/fill capture; contents are don't-care until valid
    always_ff @(posedge clk) begin
        if ((state_q == LOOKUP) && lk_ok && rq_write_q) begin
            data_q[rq_set_q][lk_way] <= lk_wline;
        end
        if (state_q == FILL) begin
            data_q[fl_set_q][fl_way] <= fl_data_q;
            tag_q[fl_set_q][fl_way]  <= fl_tag_q;
        end
        if (req_acc) begin
            rq_write_q <= bus.req_write;
            rq_set_q   <= bus.req_set;
            rq_tag_q   <= bus.req_tag;
            rq_off_q   <= bus.req_offset;
            rq_size_q  <= bus.req_size;
            rq_wdata_q <= bus.req_wdata;
        end
        if (fill_acc) begin
            fl_set_q  <= bus.fill_set;
            fl_tag_q  <= bus.fill_tag;
            fl_data_q <= bus.fill_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating counts of non-error lookup outcomes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == LOOKUP) && !lk_err) begin
            if (lk_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!lk_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_set_array.sv
// Randomised and directed bench for cache_set_array against a recency-list reference model.
// Latency: expects responses one edge after LOOKUP acceptance and evictions one edge after fill acceptance.
// Backpressure: drives only when the array is idle; checks fill-over-request priority explicitly.
module tb_cache_set_array;
    localparam int WAYS = 8, SETS = 64, BB = 64, TAG_W = 24, LINE_W = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_set_array_if #(.SET_W(6), .TAG_W(TAG_W), .OFF_W(6), .LINE_W(LINE_W)) bus ();

    cache_set_array #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-way contents plus a recency list (position 0 = most recent)
    logic [LINE_W-1:0] m_data  [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    int                m_ord   [SETS][WAYS];

    // Observed DUT values captured by the drivers
    logic              o_pre, o_v, o_hit, o_err, o_rv, o_ev;
    logic [63:0]       o_rdata;
    logic [5:0]        o_ev_set;
    logic [TAG_W-1:0]  o_ev_tag;
    logic [LINE_W-1:0] o_ev_data;

    // Expected values from the model
    bit                e_hit, e_err, e_ev;
    logic [63:0]       e_rdata;
    logic [TAG_W-1:0]  e_ev_tag;
    logic [LINE_W-1:0] e_ev_data;

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_ord[s][w]   = w;
            end
        end
    endtask

    task automatic m_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (m_ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = w;
    endtask

    task automatic m_access(input bit wr, input int s, input logic [TAG_W-1:0] tg, input int off,
                            input int sz, input logic [63:0] wd);
        int nb, way;
        nb = 1 << sz;
        way = -1;
        e_hit = 0; e_err = 0; e_rdata = '0;
        if (off + nb > BB) begin
            e_err = 1;
            return;
        end
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) way = w;
        if (way < 0) return;
        e_hit = 1;
        for (int i = 0; i < nb; i++) begin
            if (wr) m_data[s][way][8*(off+i) +: 8] = wd[8*i +: 8];
            else    e_rdata[8*i +: 8] = m_data[s][way][8*(off+i) +: 8];
        end
        if (wr) m_dirty[s][way] = 1;
        m_touch(s, way);
    endtask

    task automatic m_fill(input int s, input logic [TAG_W-1:0] tg, input logic [LINE_W-1:0] d);
        int v;
        bit match;
        v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && m_valid[s][w] && m_tag[s][w] == tg) v = w;
        match = (v >= 0);
        if (v < 0) for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) v = m_ord[s][WAYS-1];
        e_ev      = !match && m_valid[s][v] && m_dirty[s][v];
        e_ev_tag  = e_ev ? m_tag[s][v] : '0;
        e_ev_data = e_ev ? m_data[s][v] : '0;
        m_data[s][v]  = d;
        m_tag[s][v]   = tg;
        m_valid[s][v] = 1;
        m_dirty[s][v] = 0;
        m_touch(s, v);
    endtask

    task automatic drive_req(input bit wr, input int s, input logic [TAG_W-1:0] tg, input int off,
                             input int sz, input logic [63:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_set    = 6'(s);
        bus.req_tag    = tg;
        bus.req_offset = 6'(off);
        bus.req_size   = 2'(sz);
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        o_pre = bus.resp_valid;
        @(posedge clk); #1;
        o_v = bus.resp_valid; o_hit = bus.resp_hit; o_err = bus.resp_err; o_rdata = bus.resp_rdata;
    endtask

    task automatic drive_fill(input int s, input logic [TAG_W-1:0] tg, input logic [LINE_W-1:0] d);
        @(negedge clk);
        bus.fill_valid = 1'b1;
        bus.fill_set   = 6'(s);
        bus.fill_tag   = tg;
        bus.fill_data  = d;
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        @(posedge clk); #1;
        o_ev = bus.evict_valid; o_ev_set = bus.evict_set; o_ev_tag = bus.evict_tag;
        o_ev_data = bus.evict_data; o_rv = bus.resp_valid;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W/32; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        bus.req_valid = 0; bus.req_write = 0; bus.req_set = 0; bus.req_tag = 0; bus.req_offset = 0;
        bus.req_size = 0; bus.req_wdata = 0; bus.fill_valid = 0; bus.fill_set = 0; bus.fill_tag = 0;
        bus.fill_data = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.fill_ready, bus.resp_valid, bus.evict_valid, bus.resp_rdata, bus.evict_tag} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 24'd0}) begin
            errors++;
            $display("FAIL reset_outputs: rr=%b fr=%b rv=%b ev=%b rdata=%h, required rr=1 fr=1 rv=0 ev=0 rdata=0",
                     bus.req_ready, bus.fill_ready, bus.resp_valid, bus.evict_valid, bus.resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_access(0, 3, 24'h15, 0, 3, 64'd0);
        drive_req(0, 3, 24'h15, 0, 3, 64'd0);
        checks++;
        if (o_pre !== 1'b0) begin
            errors++;
            $display("FAIL resp_early: resp_valid=%b one edge after accept, required 0", o_pre);
        end
        checks++;
        if ({o_v, o_hit, o_err, o_rdata} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL cold_miss: v=%b hit=%b err=%b rdata=%h, required v=1 hit=0 err=0 rdata=0",
                     o_v, o_hit, o_err, o_rdata);
        end
    endtask

    task automatic test_fill_read();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < BB; i++) l[8*i +: 8] = 8'(i);
        m_fill(3, 24'h15, l);
        drive_fill(3, 24'h15, l);
        checks++;
        if ({o_ev, o_rv} !== 2'b00) begin
            errors++;
            $display("FAIL fill_cold_strobes: evict=%b resp=%b, required 0 0", o_ev, o_rv);
        end
        m_access(0, 3, 24'h15, 8, 2, 64'd0);
        drive_req(0, 3, 24'h15, 8, 2, 64'd0);
        checks++;
        if ({o_v, o_hit, o_err, o_rdata} !== {1'b1, 1'b1, 1'b0, 64'h0B0A0908} || e_rdata !== 64'h0B0A0908) begin
            errors++;
            $display("FAIL read_hit: v=%b hit=%b rdata=%h, required v=1 hit=1 rdata=0b0a0908", o_v, o_hit, o_rdata);
        end
        m_access(1, 3, 24'h15, 8, 0, 64'hFF);
        drive_req(1, 3, 24'h15, 8, 0, 64'hFF);
        checks++;
        if ({o_v, o_hit, o_err, o_rdata} !== {1'b1, 1'b1, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL write_hit: v=%b hit=%b err=%b rdata=%h, required 1 1 0 0", o_v, o_hit, o_err, o_rdata);
        end
        m_access(0, 3, 24'h15, 8, 2, 64'd0);
        drive_req(0, 3, 24'h15, 8, 2, 64'd0);
        checks++;
        if ({o_hit, o_rdata} !== {1'b1, 64'h0B0A09FF} || e_rdata !== 64'h0B0A09FF) begin
            errors++;
            $display("FAIL read_after_write: hit=%b rdata=%h, required hit=1 rdata=0b0a09ff", o_hit, o_rdata);
        end
    endtask

    task automatic test_evict();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 8; k++) begin
            l = rand_line();
            m_fill(3, 24'h100 + 24'(k), l);
            drive_fill(3, 24'h100 + 24'(k), l);
            checks++;
            if ({o_ev, o_ev_set, o_ev_tag, o_ev_data} !== {e_ev, e_ev ? 6'd3 : 6'd0, e_ev_tag, e_ev_data}) begin
                errors++;
                $display("FAIL evict_fill%0d: ev=%b set=%0d tag=%h, required ev=%b tag=%h", k, o_ev, o_ev_set,
                         o_ev_tag, e_ev, e_ev_tag);
            end
        end
        checks++;
        if ({o_ev, o_ev_tag, o_ev_data[71:64]} !== {1'b1, 24'h15, 8'hFF}) begin
            errors++;
            $display("FAIL dirty_victim: ev=%b tag=%h byte8=%h, required ev=1 tag=000015 byte8=ff", o_ev,
                     o_ev_tag, o_ev_data[71:64]);
        end
        l = rand_line();
        m_fill(3, 24'h200, l);
        drive_fill(3, 24'h200, l);
        checks++;
        if ({o_ev, o_ev_tag, o_ev_data} !== {1'b0, 24'd0, 512'd0}) begin
            errors++;
            $display("FAIL clean_victim: ev=%b tag=%h, required ev=0 tag=0 data=0", o_ev, o_ev_tag);
        end
        m_access(0, 3, 24'h15, 0, 3, 64'd0);
        drive_req(0, 3, 24'h15, 0, 3, 64'd0);
        checks++;
        if ({o_v, o_hit} !== 2'b10) begin
            errors++;
            $display("FAIL evicted_misses: v=%b hit=%b, required v=1 hit=0", o_v, o_hit);
        end
    endtask

    task automatic test_priority_and_err();
        logic [LINE_W-1:0] l;
        l = rand_line();
        @(negedge clk);
        bus.fill_valid = 1; bus.fill_set = 6'd3; bus.fill_tag = 24'h300; bus.fill_data = l;
        bus.req_valid = 1; bus.req_write = 0; bus.req_set = 6'd3; bus.req_tag = 24'h104;
        bus.req_offset = 6'd4; bus.req_size = 2'd2; bus.req_wdata = 64'd0;
        #1;
        checks++;
        if ({bus.req_ready, bus.fill_ready} !== 2'b01) begin
            errors++;
            $display("FAIL prio_ready: req_ready=%b fill_ready=%b, required 0 1", bus.req_ready, bus.fill_ready);
        end
        m_fill(3, 24'h300, l);
        m_access(0, 3, 24'h104, 4, 2, 64'd0);
        @(posedge clk); #1;
        bus.fill_valid = 0;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_busy: req_ready=%b during fill, required 0", bus.req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.evict_valid, bus.evict_tag, bus.resp_valid, bus.req_ready} !== {e_ev, e_ev_tag, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL prio_fill_done: ev=%b tag=%h rv=%b rr=%b, required ev=%b tag=%h rv=0 rr=1",
                     bus.evict_valid, bus.evict_tag, bus.resp_valid, bus.req_ready, e_ev, e_ev_tag);
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        checks++;
        if ({bus.resp_valid, bus.resp_hit, bus.resp_rdata} !== {1'b1, e_hit, e_rdata}) begin
            errors++;
            $display("FAIL prio_req_resp: v=%b hit=%b rdata=%h, required v=1 hit=%b rdata=%h", bus.resp_valid,
                     bus.resp_hit, bus.resp_rdata, e_hit, e_rdata);
        end
        m_access(1, 3, 24'h102, 62, 2, 64'hDEADBEEF);
        drive_req(1, 3, 24'h102, 62, 2, 64'hDEADBEEF);
        checks++;
        if ({o_v, o_hit, o_err, o_rdata} !== {1'b1, 1'b0, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL err_cross: v=%b hit=%b err=%b rdata=%h, required 1 0 1 0", o_v, o_hit, o_err, o_rdata);
        end
        m_access(0, 3, 24'h102, 56, 3, 64'd0);
        drive_req(0, 3, 24'h102, 56, 3, 64'd0);
        checks++;
        if ({o_v, o_hit, o_err, o_rdata} !== {1'b1, e_hit, 1'b0, e_rdata} || e_hit !== 1'b1) begin
            errors++;
            $display("FAIL err_nochange: hit=%b err=%b rdata=%h, required hit=1 err=0 rdata=%h", o_hit, o_err,
                     o_rdata, e_rdata);
        end
    endtask

    task automatic test_random();
        int op, s, off, sz, n_bad;
        logic [TAG_W-1:0] tg;
        logic [LINE_W-1:0] l;
        logic [63:0] wd;
        n_bad = 0;
        for (int it = 0; it < 400; it++) begin
            op  = $urandom_range(0, 9);
            s   = $urandom_range(1, 2);
            tg  = 24'h40 + 24'($urandom_range(0, 11));
            off = $urandom_range(0, BB-1);
            sz  = $urandom_range(0, 3);
            wd  = {$urandom, $urandom};
            if (op < 3) begin
                l = rand_line();
                m_fill(s, tg, l);
                drive_fill(s, tg, l);
                checks++;
                if ({o_ev, o_ev_set, o_ev_tag, o_ev_data, o_rv} !==
                    {e_ev, e_ev ? 6'(s) : 6'd0, e_ev_tag, e_ev_data, 1'b0}) begin
                    errors++;
                    $display("FAIL rand_fill it%0d: ev=%b set=%0d tag=%h rv=%b, required ev=%b tag=%h", it, o_ev,
                             o_ev_set, o_ev_tag, o_rv, e_ev, e_ev_tag);
                end
            end else begin
                m_access(op >= 7, s, tg, off, sz, wd);
                drive_req(op >= 7, s, tg, off, sz, wd);
                checks++;
                if ({o_pre, o_v, o_hit, o_err, o_rdata} !== {1'b0, 1'b1, e_hit, e_err, e_rdata}) begin
                    errors++;
                    $display("FAIL rand_req it%0d: v=%b hit=%b err=%b rdata=%h, required hit=%b err=%b rdata=%h",
                             it, o_v, o_hit, o_err, o_rdata, e_hit, e_err, e_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [LINE_W-1:0] l;
        int seen;
        l = rand_line();
        m_fill(7, 24'h33, l);
        drive_fill(7, 24'h33, l);
        m_access(0, 7, 24'h33, 0, 3, 64'd0);
        drive_req(0, 7, 24'h33, 0, 3, 64'd0);
        checks++;
        if ({o_hit, o_rdata} !== {1'b1, l[63:0]}) begin
            errors++;
            $display("FAIL pre_reset_hit: hit=%b rdata=%h, required hit=1 rdata=%h", o_hit, o_rdata, l[63:0]);
        end
        @(negedge clk);
        bus.req_valid = 1; bus.req_write = 0; bus.req_set = 6'd7; bus.req_tag = 24'h33;
        bus.req_offset = 0; bus.req_size = 2'd3;
        @(posedge clk); #1;
        bus.req_valid = 0;
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({bus.req_ready, bus.fill_ready, bus.resp_valid, bus.evict_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_reset_outputs: rr=%b fr=%b rv=%b ev=%b, required 1 1 0 0", bus.req_ready,
                     bus.fill_ready, bus.resp_valid, bus.evict_valid);
        end
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (bus.resp_valid) seen++;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_noresp: resp_valid seen %0d cycles, required 0", seen);
        end
        m_access(0, 7, 24'h33, 0, 3, 64'd0);
        drive_req(0, 7, 24'h33, 0, 3, 64'd0);
        checks++;
        if ({o_v, o_hit, o_rdata} !== {1'b1, 1'b0, 64'd0} || e_hit !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_miss: v=%b hit=%b rdata=%h, required v=1 hit=0 rdata=0", o_v, o_hit, o_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_evict();
        test_priority_and_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end
endmodule
